// File: rtl/uart_tx_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_sched
//   Round-robin scheduler that shares the UART TX CSR block between two byte
//   requesters. For each accepted byte it acts as a local-bus master:
//     1. poll U_TX_STAT (0x4) until READY (bit 5) is set,
//     2. write the byte to U_TX_DATA (0x0, strobe 0001),
//     3. write TX_START (bit 9) to U_TX_CTRL (0x8, strobe 0010),
//     4. poll U_TX_STAT until TX_DONE (bit 13) is set, or abort on timeout.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/data/ready     byte requesters 0 and 1 (valid/ready handshake)
//   busy                      a transfer is in progress
//   grant_id                  requester owning the current/last transfer
//   timeout_err               one-cycle pulse when TX_DONE polling times out
//   waddr/wdata/wen/wstrb     bus write channel, held until wready
//   raddr/ren                 bus read request (single-cycle pulse)
//   rdata/rvalid              bus read response, one cycle after ren
// -----------------------------------------------------------------------------
module uart_tx_sched #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STRB_W      = DATA_W / 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [7:0]        req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [7:0]        req1_data,
  output logic              req1_ready,
  output logic              busy,
  output logic              grant_id,
  output logic              timeout_err,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              wen,
  output logic [STRB_W-1:0] wstrb,
  input  logic              wready,
  output logic [ADDR_W-1:0] raddr,
  output logic              ren,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_DATA = ADDR_W'(32'h0000_0000);
  localparam logic [ADDR_W-1:0] ADDR_STAT = ADDR_W'(32'h0000_0004);
  localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(32'h0000_0008);
  localparam logic [DATA_W-1:0] TX_START  = DATA_W'(32'h0000_0200);
  localparam logic [STRB_W-1:0] STRB_DAT  = STRB_W'(4'b0001);
  localparam logic [STRB_W-1:0] STRB_GO   = STRB_W'(4'b0010);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_RDY = 3'd1,
    WT_RDY = 3'd2,
    WR_DAT = 3'd3,
    WR_GO  = 3'd4,
    RD_DN  = 3'd5,
    WT_DN  = 3'd6
  } state_t;

  state_t            state_q;
  logic              last_id_q;   // requester served most recently (rr pointer)
  logic              grant_id_q;
  logic [7:0]        byte_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ren_q;
  logic [ADDR_W-1:0] raddr_q;
  logic              wen_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              timeout_err_q;

  logic              accept_d;
  logic              win_id_d;
  logic [7:0]        win_byte_d;
  logic              rdy_bit_s;
  logic              done_hit_s;
  logic              cnt_max_s;

  // Only READY and TX_DONE of the status word matter.
  logic              unused_rdata;
  assign unused_rdata = ^{rdata[DATA_W-1:14], rdata[12:6], rdata[4:0]};

  assign rdy_bit_s  = rdata[5];
  assign done_hit_s = rvalid && rdata[13];
  assign cnt_max_s  = (cnt_q == CNT_MAX);

  // Arbitration: a lone valid requester wins; on contention the one not
  // served last wins. Ready is offered only while idle and out of reset.
  always_comb begin
    accept_d = 1'b0;
    win_id_d = 1'b0;
    if (!rst && (state_q == IDLE)) begin
      if (req0_valid && req1_valid) begin
        accept_d = 1'b1;
        win_id_d = ~last_id_q;
      end else if (req0_valid) begin
        accept_d = 1'b1;
        win_id_d = 1'b0;
      end else if (req1_valid) begin
        accept_d = 1'b1;
        win_id_d = 1'b1;
      end else begin
        accept_d = 1'b0;
        win_id_d = 1'b0;
      end
    end else begin
      accept_d = 1'b0;
      win_id_d = 1'b0;
    end
  end

  assign win_byte_d = win_id_d ? req1_data : req0_data;
  assign req0_ready = accept_d && !win_id_d;
  assign req1_ready = accept_d && win_id_d;

  // Transfer FSM; bus outputs are registered and loaded on the transition
  // into the state that drives them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_id_q     <= 1'b1;
      grant_id_q    <= 1'b0;
      byte_q        <= 8'h00;
      cnt_q         <= '0;
      ren_q         <= 1'b0;
      raddr_q       <= '0;
      wen_q         <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      ren_q         <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            grant_id_q <= win_id_d;
            byte_q     <= win_byte_d;
            ren_q      <= 1'b1;
            raddr_q    <= ADDR_STAT;
            state_q    <= RD_RDY;
          end
        end
        RD_RDY: state_q <= WT_RDY;
        WT_RDY: begin
          if (rvalid) begin
            if (rdy_bit_s) begin
              wen_q   <= 1'b1;
              waddr_q <= ADDR_DATA;
              wdata_q <= DATA_W'(byte_q);
              wstrb_q <= STRB_DAT;
              state_q <= WR_DAT;
            end else begin
              ren_q   <= 1'b1;
              state_q <= RD_RDY;
            end
          end
        end
        WR_DAT: begin
          if (wready) begin
            waddr_q <= ADDR_CTRL;
            wdata_q <= TX_START;
            wstrb_q <= STRB_GO;
            state_q <= WR_GO;
          end
        end
        WR_GO: begin
          if (wready) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
            ren_q   <= 1'b1;
            raddr_q <= ADDR_STAT;
            state_q <= RD_DN;
          end
        end
        RD_DN: begin
          if (cnt_max_s) begin
            timeout_err_q <= 1'b1;
            last_id_q     <= grant_id_q;
            state_q       <= IDLE;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= WT_DN;
          end
        end
        WT_DN: begin
          // A done response in the last allowed cycle beats the timeout.
          if (done_hit_s) begin
            last_id_q <= grant_id_q;
            state_q   <= IDLE;
          end else if (cnt_max_s) begin
            timeout_err_q <= 1'b1;
            last_id_q     <= grant_id_q;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (rvalid) begin
              ren_q   <= 1'b1;
              state_q <= RD_DN;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;
  assign ren         = ren_q;
  assign raddr       = raddr_q;
  assign wen         = wen_q;
  assign waddr       = waddr_q;
  assign wdata       = wdata_q;
  assign wstrb       = wstrb_q;

endmodule
